// File: rtl/sram_bus_ctrl.sv
// Single-port synchronous SRAM behind a small access FSM: optional read-data inversion,
// one-cycle output drive window, and a programmable bus-turnaround gap before the next request.
module sram_bus_ctrl #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 256,
  parameter int TURN_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs_n,
  input  logic              we_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  input  logic              inv,
  output logic [DATA_W-1:0] dout,
  output logic              dout_oe,
  output logic              dout_valid,
  output logic              busy,
  output logic              err
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRIVE, TURN} state_t;

  localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W+1)'(DEPTH);
  localparam logic [1:0]      TURN_LAST = (TURN_CYCLES > 0) ? 2'(TURN_CYCLES - 1) : 2'd0;

  state_t            state;
  state_t            state_next;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] addr_q;
  logic              inv_q;
  logic              oor_q;
  logic [1:0]        turn_cnt;
  logic              accept;
  logic              oor;

  // busy and the drive strobes come straight from the state register, so reset clears them at once
  assign busy       = (state != IDLE);
  assign accept     = !cs_n && !busy;
  assign oor        = ({1'b0, addr} >= DEPTH_L);
  assign dout_oe    = (state == DRIVE);
  assign dout_valid = (state == DRIVE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = we_n ? READ : WRITE;
      WRITE:   state_next = IDLE;
      READ:    state_next = DRIVE;
      DRIVE:   state_next = (TURN_CYCLES > 0) ? TURN : IDLE;
      TURN:    if (turn_cnt == 2'd0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      inv_q    <= 1'b0;
      oor_q    <= 1'b0;
      dout     <= '0;
      err      <= 1'b0;
      turn_cnt <= 2'd0;
    end else begin
      err <= accept && oor;
      if (accept) begin
        addr_q <= addr;
        inv_q  <= inv;
        oor_q  <= oor;
      end
      // out-of-range reads return zero without inversion
      if (state == READ)
        dout <= oor_q ? '0 : (mem[addr_q] ^ {DATA_W{inv_q}});
      if (state == DRIVE)
        turn_cnt <= TURN_LAST;
      else if (state == TURN && turn_cnt != 2'd0)
        turn_cnt <= turn_cnt - 2'd1;
    end
  end

  // Array is deliberately not reset; writes commit at the accept edge
  always_ff @(posedge clk) begin
    if (accept && !we_n && !oor)
      mem[addr] <= din;
  end

endmodule

// File: tb/tb_sram_bus_ctrl.sv
// Bench for sram_bus_ctrl: directed and random accesses against an array model of memory.
module tb_sram_bus_ctrl;

  logic       clk;
  logic       rst_n;
  logic       cs_n, we_n, inv;
  logic [7:0] addr, din;
  logic [7:0] dout;
  logic       dout_oe, dout_valid, busy, err;

  logic       cs_n_b, we_n_b, inv_b;
  logic [7:0] addr_b, din_b;
  logic [7:0] dout_b;
  logic       dout_oe_b, dout_valid_b, busy_b, err_b;

  int errors = 0;
  int checks = 0;

  logic [7:0] mref  [256];
  bit         known [256];

  sram_bus_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH(200), .TURN_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .we_n(we_n), .addr(addr), .din(din), .inv(inv),
    .dout(dout), .dout_oe(dout_oe), .dout_valid(dout_valid), .busy(busy), .err(err)
  );

  sram_bus_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .TURN_CYCLES(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n_b), .we_n(we_n_b), .addr(addr_b), .din(din_b), .inv(inv_b),
    .dout(dout_b), .dout_oe(dout_oe_b), .dout_valid(dout_valid_b), .busy(busy_b), .err(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    cs_n = 1'b0; we_n = 1'b0; addr = a; din = d; inv = 1'($urandom_range(0, 1));
    @(negedge clk);
    cs_n = 1'b1;
    chk1("wr_busy", busy, 1'b1);
    chk1("wr_err", err, a >= 8'd200);
    if (a < 8'd200) begin
      mref[a]  = d;
      known[a] = 1'b1;
    end
    @(negedge clk);
    chk1("wr_idle", busy, 1'b0);
    chk1("wr_err_clr", err, 1'b0);
  endtask

  task automatic rd(input logic [7:0] a, input logic iv);
    logic       oor;
    logic [7:0] exp;
    oor = (a >= 8'd200);
    exp = oor ? 8'h00 : (mref[a] ^ {8{iv}});
    @(negedge clk);
    cs_n = 1'b0; we_n = 1'b1; addr = a; inv = iv; din = 8'($urandom);
    @(negedge clk);
    cs_n = 1'b1;
    chk1("rd_busy_read", busy, 1'b1);
    chk1("rd_err", err, oor);
    chk1("rd_oe_read", dout_oe, 1'b0);
    chk1("rd_valid_read", dout_valid, 1'b0);
    @(negedge clk);
    chk1("rd_oe_drive", dout_oe, 1'b1);
    chk1("rd_valid_drive", dout_valid, 1'b1);
    chk1("rd_err_clr", err, 1'b0);
    if (oor || known[a]) chk8("rd_dout", dout, exp);
    @(negedge clk);
    chk1("rd_oe_turn", dout_oe, 1'b0);
    chk1("rd_valid_turn", dout_valid, 1'b0);
    chk1("rd_busy_turn", busy, 1'b1);
    if (oor || known[a]) chk8("rd_dout_hold", dout, exp);
    @(negedge clk);
    chk1("rd_idle", busy, 1'b0);
  endtask

  initial begin
    int         pulses;
    logic       prev_oe;
    logic [7:0] a;

    foreach (known[i]) known[i] = 1'b0;
    rst_n = 1'b0;
    cs_n = 1'b1; we_n = 1'b1; addr = 8'h00; din = 8'h00; inv = 1'b0;
    cs_n_b = 1'b1; we_n_b = 1'b1; addr_b = 8'h00; din_b = 8'h00; inv_b = 1'b0;

    #3;
    chk8("rst_dout", dout, 8'h00);
    chk1("rst_oe", dout_oe, 1'b0);
    chk1("rst_valid", dout_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk8("rst_dout_b", dout_b, 8'h00);
    chk1("rst_oe_b", dout_oe_b, 1'b0);
    chk1("rst_busy_b", busy_b, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // T1 / T2: write then plain and inverted reads
    wr(8'h05, 8'hA5);
    rd(8'h05, 1'b0);
    rd(8'h05, 1'b1);
    rd(8'h05, 1'b0);

    // T4: range boundary with DEPTH=200
    wr(8'hC7, 8'h3C);
    wr(8'hC8, 8'hFF);
    rd(8'hC8, 1'b1);
    rd(8'hC7, 1'b0);

    // Seed the addresses the random phase touches
    for (int i = 0; i < 16; i++) wr(8'(i), 8'($urandom));
    for (int i = 195; i < 200; i++) wr(8'(i), 8'($urandom));

    // T3: cs_n held low, reads at 0,1,2 accepted every 4 edges
    @(negedge clk);
    cs_n = 1'b0; we_n = 1'b1; addr = 8'h00; inv = 1'b0;
    pulses = 0;
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      if (k == 0) addr = 8'h01;
      if (k == 4) addr = 8'h02;
      if (k == 8) cs_n = 1'b1;
      chk1("t3_valid", dout_valid, (k == 1 || k == 5 || k == 9));
      chk1("t3_oe", dout_oe, (k == 1 || k == 5 || k == 9));
      chk1("t3_busy", busy, (k <= 10) ? (k % 4 != 3) : 1'b0);
      if (dout_valid) begin
        pulses++;
        if (k == 1 || k == 5 || k == 9) chk8("t3_dout", dout, mref[k / 4]);
      end
    end
    chk8("t3_pulses", 8'(pulses), 8'd3);

    // Random mixed traffic
    for (int n = 0; n < 40; n++) begin
      a = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(195, 205));
      if ($urandom_range(0, 2) == 0) wr(a, 8'($urandom));
      else                           rd(a, 1'($urandom_range(0, 1)));
    end

    // T5: reset while in DRIVE
    @(negedge clk);
    cs_n = 1'b0; we_n = 1'b1; addr = 8'h05; inv = 1'b0;
    @(negedge clk);
    cs_n = 1'b1;
    @(negedge clk);
    chk1("t5_oe_drive", dout_oe, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk1("t5_oe_async", dout_oe, 1'b0);
    chk1("t5_valid_async", dout_valid, 1'b0);
    chk1("t5_busy_async", busy, 1'b0);
    chk8("t5_dout_async", dout, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk1("t5_busy_after", busy, 1'b0);
    chk1("t5_valid_after", dout_valid, 1'b0);
    rd(8'h05, 1'b0);

    // T6: TURN_CYCLES=0 instance, back-to-back reads every 3 edges
    @(negedge clk);
    cs_n_b = 1'b0; we_n_b = 1'b0; addr_b = 8'h03; din_b = 8'h96;
    @(negedge clk);
    cs_n_b = 1'b1; we_n_b = 1'b1;
    chk1("t6_wr_busy", busy_b, 1'b1);
    @(negedge clk);
    chk1("t6_wr_idle", busy_b, 1'b0);
    cs_n_b = 1'b0; inv_b = 1'b0;
    prev_oe = 1'b0;
    for (int k = 0; k <= 9; k++) begin
      @(negedge clk);
      if (k == 6) cs_n_b = 1'b1;
      chk1("t6_oe", dout_oe_b, (k == 1 || k == 4 || k == 7));
      chk1("t6_busy", busy_b, (k <= 7) ? (k % 3 != 2) : 1'b0);
      chk1("t6_oe_pair", dout_oe_b && prev_oe, 1'b0);
      if (dout_oe_b) chk8("t6_dout", dout_b, 8'h96);
      prev_oe = dout_oe_b;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
